// File: rtl/screenchar_text_renderer.sv
// -----------------------------------------------------------------------------
// screenchar_text_renderer
//
// Purpose:
//   Read-side consumer of the 256-byte screen character memory. It follows the
//   VGA pixel scan, turns every pixel inside a 32x8-cell text window (8x16
//   pixel cells, 256x128 pixels) into a character-memory address, fetches the
//   character code, then fetches the matching glyph row from the font ROM and
//   picks out the bit for the current pixel. A frame-based blink phase gates
//   characters whose code has bit 7 set.
//
//   Pipeline (one pixel per clock, no stalls):
//     edge E   : S1  - window test, char_rd_add, column offset, glyph row
//     edge E+1 : S2  - memory latches char_rd_add (alignment stage here)
//     edge E+2 : S3  - font_add from q, blank / blink visibility resolved
//     edge E+3 : S3b - font ROM latches font_add (alignment stage here)
//     edge E+4 : S4  - text_on / text_pixel registered
//
// Parameters:
//   ORIGIN_X      left pixel column of the text window
//   ORIGIN_Y      top pixel row of the text window
//   BLINK_FRAMES  frames per blink half-period (must be >= 1)
//
// Ports:
//   clock         pixel clock (also clocks the memory read port and font ROM)
//   reset         synchronous, active-high
//   pixel_x/y     current scan position, qualified by pixel_valid
//   pixel_valid   active-video qualifier
//   frame_start   one-cycle pulse at the start of each frame
//   char_rd_add   character memory read address
//   char_rd_data  character memory q (one cycle after its address latch)
//   font_add      font ROM address {glyph[6:0], glyph_row[3:0]}
//   font_data     font ROM row (one cycle after its address latch), bit 7 = left
//   text_on       pixel lies inside the text window
//   text_pixel    pixel is lit
// -----------------------------------------------------------------------------
module screenchar_text_renderer #(
  parameter logic [9:0] ORIGIN_X     = 10'd0,
  parameter logic [9:0] ORIGIN_Y     = 10'd0,
  parameter logic [5:0] BLINK_FRAMES = 6'd30
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [9:0]  pixel_x,
  input  logic [9:0]  pixel_y,
  input  logic        pixel_valid,
  input  logic        frame_start,
  output logic [7:0]  char_rd_add,
  input  logic [7:0]  char_rd_data,
  output logic [10:0] font_add,
  input  logic [7:0]  font_data,
  output logic        text_on,
  output logic        text_pixel
);

  // Window bounds are compared at 11 bits so that an origin near the top of
  // the 10-bit range does not wrap the upper bound.
  localparam logic [10:0] X_LO = {1'b0, ORIGIN_X};
  localparam logic [10:0] X_HI = X_LO + 11'd256;
  localparam logic [10:0] Y_LO = {1'b0, ORIGIN_Y};
  localparam logic [10:0] Y_HI = Y_LO + 11'd128;
  localparam logic [5:0]  BLINK_LAST = BLINK_FRAMES - 6'd1;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  // S1
  logic [7:0]  char_rd_add_q, char_rd_add_d;
  logic        s1_in_win_q,   s1_in_win_d;
  logic [2:0]  s1_xoff_q,     s1_xoff_d;
  logic [3:0]  s1_row_q,      s1_row_d;
  // S2 (memory access in flight)
  logic        s2_in_win_q,   s2_in_win_d;
  logic [2:0]  s2_xoff_q,     s2_xoff_d;
  logic [3:0]  s2_row_q,      s2_row_d;
  // S3
  logic [10:0] font_add_q,    font_add_d;
  logic        s3_in_win_q,   s3_in_win_d;
  logic [2:0]  s3_xoff_q,     s3_xoff_d;
  logic        s3_blank_q,    s3_blank_d;
  logic        s3_show_q,     s3_show_d;
  // S3b (font ROM access in flight)
  logic        s4_in_win_q,   s4_in_win_d;
  logic [2:0]  s4_xoff_q,     s4_xoff_d;
  logic        s4_blank_q,    s4_blank_d;
  logic        s4_show_q,     s4_show_d;
  // S4 outputs
  logic        text_on_q,     text_on_d;
  logic        text_pixel_q,  text_pixel_d;
  // Blink
  logic [5:0]  frame_cnt_q,   frame_cnt_d;
  logic        blink_phase_q, blink_phase_d;

  // Window-relative offsets; forced to zero outside the window so nothing
  // downstream ever sees a wrapped negative offset.
  logic        in_win;
  logic [7:0]  dx;
  logic [6:0]  dy;
  logic        font_bit;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    in_win = pixel_valid
          && ({1'b0, pixel_x} >= X_LO) && ({1'b0, pixel_x} < X_HI)
          && ({1'b0, pixel_y} >= Y_LO) && ({1'b0, pixel_y} < Y_HI);

    dx = '0;
    dy = '0;
    if (in_win) begin
      dx = 8'(pixel_x - ORIGIN_X);
      dy = 7'(pixel_y - ORIGIN_Y);
    end

    // S1: address is row-major, 32 cells per text row. Outside the window the
    // read address is left alone so the memory port does not toggle needlessly.
    char_rd_add_d = char_rd_add_q;
    if (in_win) begin
      char_rd_add_d = {dy[6:4], dx[7:3]};
    end
    s1_in_win_d = in_win;
    s1_xoff_d   = dx[2:0];
    s1_row_d    = dy[3:0];

    // S2: carry side-band alongside the memory read.
    s2_in_win_d = s1_in_win_q;
    s2_xoff_d   = s1_xoff_q;
    s2_row_d    = s1_row_q;

    // S3: character code is now on q. Blink visibility is decided here, using
    // the phase current at this edge, so a phase toggle only affects pixels
    // that reach S3 after it.
    font_add_d = font_add_q;
    if (s2_in_win_q) begin
      font_add_d = {char_rd_data[6:0], s2_row_q};
    end
    s3_in_win_d = s2_in_win_q;
    s3_xoff_d   = s2_xoff_q;
    s3_blank_d  = (char_rd_data[6:0] == 7'd0);
    s3_show_d   = !char_rd_data[7] || blink_phase_q;

    // S3b: carry side-band alongside the font ROM read.
    s4_in_win_d = s3_in_win_q;
    s4_xoff_d   = s3_xoff_q;
    s4_blank_d  = s3_blank_q;
    s4_show_d   = s3_show_q;

    // S4: glyph row is on font_data; bit 7 is the leftmost pixel of the cell.
    font_bit     = font_data[3'd7 - s4_xoff_q];
    text_on_d    = s4_in_win_q;
    text_pixel_d = s4_in_win_q && !s4_blank_q && s4_show_q && font_bit;

    // Blink: count frames, flip the phase every BLINK_FRAMES frames.
    frame_cnt_d   = frame_cnt_q;
    blink_phase_d = blink_phase_q;
    if (frame_start) begin
      if (frame_cnt_q == BLINK_LAST) begin
        frame_cnt_d   = 6'd0;
        blink_phase_d = !blink_phase_q;
      end else begin
        frame_cnt_d = frame_cnt_q + 6'd1;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      char_rd_add_q <= '0;
      s1_in_win_q   <= 1'b0;
      s1_xoff_q     <= '0;
      s1_row_q      <= '0;
      s2_in_win_q   <= 1'b0;
      s2_xoff_q     <= '0;
      s2_row_q      <= '0;
      font_add_q    <= '0;
      s3_in_win_q   <= 1'b0;
      s3_xoff_q     <= '0;
      s3_blank_q    <= 1'b0;
      s3_show_q     <= 1'b0;
      s4_in_win_q   <= 1'b0;
      s4_xoff_q     <= '0;
      s4_blank_q    <= 1'b0;
      s4_show_q     <= 1'b0;
      text_on_q     <= 1'b0;
      text_pixel_q  <= 1'b0;
      frame_cnt_q   <= '0;
      blink_phase_q <= 1'b1;
    end else begin
      char_rd_add_q <= char_rd_add_d;
      s1_in_win_q   <= s1_in_win_d;
      s1_xoff_q     <= s1_xoff_d;
      s1_row_q      <= s1_row_d;
      s2_in_win_q   <= s2_in_win_d;
      s2_xoff_q     <= s2_xoff_d;
      s2_row_q      <= s2_row_d;
      font_add_q    <= font_add_d;
      s3_in_win_q   <= s3_in_win_d;
      s3_xoff_q     <= s3_xoff_d;
      s3_blank_q    <= s3_blank_d;
      s3_show_q     <= s3_show_d;
      s4_in_win_q   <= s4_in_win_d;
      s4_xoff_q     <= s4_xoff_d;
      s4_blank_q    <= s4_blank_d;
      s4_show_q     <= s4_show_d;
      text_on_q     <= text_on_d;
      text_pixel_q  <= text_pixel_d;
      frame_cnt_q   <= frame_cnt_d;
      blink_phase_q <= blink_phase_d;
    end
  end

  assign char_rd_add = char_rd_add_q;
  assign font_add    = font_add_q;
  assign text_on     = text_on_q;
  assign text_pixel  = text_pixel_q;

endmodule
